// File: rtl/friscv_pkg.sv
// Shared types for the instruction fetch slice:
// fetch FSM states, buffered entry layout, default depth.
package friscv_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between
// the fetch unit (master) and memory (slave).
interface ifetch_unit_if;
  import friscv_pkg::*;

  logic            imem_req_out;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_gnt_in;
  logic            imem_rvalid_in;
  logic [XLEN-1:0] imem_rdata_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_gnt_in,
    input  imem_rvalid_in,
    input  imem_rdata_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_gnt_in,
    output imem_rvalid_in,
    output imem_rdata_in
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read
// straight from the storage registers.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the MSB alone means full
  assign full_o  = cnt_q[AW];
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // pointers wrap modulo DEPTH; flush empties at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !flush_i)
  ) else $error("push into full fifo");

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem request,
// responses buffered in a small FIFO for decode.
module ifetch_unit
  import friscv_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance_out,
  input  logic            flush_in,
  ifetch_unit_if.master   imem,
  output logic            instr_valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc_out,
  input  logic            instr_ready_in
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            req;
  logic            push;
  logic            full;
  logic            empty;
  fetch_entry_t    wentry;
  fetch_entry_t    rentry;

  assign imem.imem_addr_out = pc_in;
  assign imem.imem_req_out  = req;
  assign wentry = '{pc: pend_q, instr: imem.imem_rdata_in};

  assign instr_valid_out = ~empty;
  assign instr_out       = rentry.instr;
  assign instr_pc_out    = rentry.pc;

  // state and pending fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // issue one request; a free slot exists at grant
  // time, and pops only free more while waiting
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    req            = 1'b0;
    pc_advance_out = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = rst_n & ~full & ~flush_in;
        if (req && imem.imem_gnt_in) begin
          pc_advance_out = 1'b1;
          pend_d         = pc_in;
          state_d        = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (imem.imem_rvalid_in) begin
          push    = ~flush_in;
          state_d = IDLE;
        end else if (flush_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_in),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (instr_ready_in),
    .rdata_o (rentry),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a queue-based
// reference model checked every cycle.
module tb_ifetch_unit;
  import friscv_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic            pc_advance_out;
  logic            flush_in = 1'b0;
  logic            instr_valid_out;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc_out;
  logic            instr_ready_in = 1'b0;

  ifetch_unit_if imem ();

  int nvec = 0;
  int nerr = 0;

  // model: buffered {pc,instr} list and outstanding fetch
  logic [63:0] mq[$];
  bit          m_out  = 0;
  bit          m_disc = 0;
  logic [31:0] m_pc   = '0;

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_in           (pc_in),
    .pc_advance_out  (pc_advance_out),
    .flush_in        (flush_in),
    .imem            (imem),
    .instr_valid_out (instr_valid_out),
    .instr_out       (instr_out),
    .instr_pc_out    (instr_pc_out),
    .instr_ready_in  (instr_ready_in)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model update on each rising edge
  always @(posedge clk) begin
    bit g, pu, po;
    if (!rst_n) begin
      mq.delete();
      m_out  = 0;
      m_disc = 0;
      m_pc   = '0;
    end else begin
      g  = !m_out && mq.size() < DEPTH && !flush_in
           && imem.imem_gnt_in;
      pu = m_out && !m_disc && imem.imem_rvalid_in
           && !flush_in;
      po = mq.size() != 0 && instr_ready_in;
      if (flush_in) mq.delete();
      else begin
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back({m_pc, imem.imem_rdata_in});
      end
      if (m_out && imem.imem_rvalid_in) m_out = 0;
      else if (m_out && flush_in) m_disc = 1;
      if (g) begin
        m_out  = 1;
        m_disc = 0;
        m_pc   = pc_in;
      end
    end
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    logic        e_req, e_val;
    logic [31:0] e_ins, e_pc;
    #1;
    e_req = rst_n && !m_out && mq.size() < DEPTH && !flush_in;
    e_val = rst_n && mq.size() != 0;
    e_ins = '0;
    e_pc  = '0;
    if (e_val) begin
      e_ins = mq[0][31:0];
      e_pc  = mq[0][63:32];
    end
    chk("req", {31'd0, imem.imem_req_out}, {31'd0, e_req});
    chk("adv", {31'd0, pc_advance_out},
        {31'd0, e_req & imem.imem_gnt_in});
    chk("addr", imem.imem_addr_out, pc_in);
    chk("valid", {31'd0, instr_valid_out}, {31'd0, e_val});
    chk("instr", instr_out, e_ins);
    chk("ipc", instr_pc_out, e_pc);
  end

  task automatic cyc(input logic r, input logic [31:0] pc,
                     input logic g, input logic rv,
                     input logic [31:0] rd, input logic fl,
                     input logic rdy);
    @(negedge clk);
    rst_n               = r;
    pc_in               = pc;
    imem.imem_gnt_in    = g;
    imem.imem_rvalid_in = rv;
    imem.imem_rdata_in  = rd;
    flush_in            = fl;
    instr_ready_in      = rdy;
    #2;
  endtask

  initial begin
    imem.imem_gnt_in    = 1'b0;
    imem.imem_rvalid_in = 1'b0;
    imem.imem_rdata_in  = '0;

    // reset state
    cyc(0, 32'h0, 1, 0, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem.imem_req_out}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_out}, 32'd0);

    // back-to-back fetch pc 0 then 4, decode stalled
    cyc(1, 32'h0, 1, 0, 0, 0, 0);
    chk("t1_adv0", {31'd0, pc_advance_out}, 32'd1);
    cyc(1, 32'h4, 1, 1, 32'h11, 0, 0);
    chk("t1_wait_req", {31'd0, imem.imem_req_out}, 32'd0);
    cyc(1, 32'h4, 1, 0, 0, 0, 0);
    chk("t1_head_pc", instr_pc_out, 32'h0);
    chk("t1_head_ins", instr_out, 32'h11);
    chk("t1_adv1", {31'd0, pc_advance_out}, 32'd1);
    cyc(1, 32'h8, 0, 1, 32'h22, 0, 0);
    // buffer full: no further requests
    cyc(1, 32'h8, 1, 0, 0, 0, 0);
    chk("full_req", {31'd0, imem.imem_req_out}, 32'd0);
    cyc(1, 32'h8, 1, 0, 0, 0, 0);
    chk("full_req2", {31'd0, imem.imem_req_out}, 32'd0);
    cyc(1, 32'h8, 1, 0, 0, 0, 1);
    chk("full_req_pop", {31'd0, imem.imem_req_out}, 32'd0);
    cyc(1, 32'h8, 1, 0, 0, 0, 0);
    chk("t1_head2_pc", instr_pc_out, 32'h4);
    chk("t1_head2_ins", instr_out, 32'h22);
    chk("refill_req", {31'd0, imem.imem_req_out}, 32'd1);
    // push and pop together at count=1
    cyc(1, 32'hC, 0, 1, 32'h33, 0, 1);
    cyc(1, 32'hC, 0, 0, 0, 0, 0);
    chk("pp_valid", {31'd0, instr_valid_out}, 32'd1);
    chk("pp_pc", instr_pc_out, 32'h8);
    chk("pp_ins", instr_out, 32'h33);
    cyc(1, 32'hC, 0, 0, 0, 0, 1);
    cyc(1, 32'hC, 0, 0, 0, 0, 0);
    chk("pp_empty", {31'd0, instr_valid_out}, 32'd0);

    // flush while waiting, late response dropped
    cyc(1, 32'h20, 1, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 1, 0);
    cyc(1, 32'h100, 1, 1, 32'hDEADBEEF, 0, 0);
    chk("drain_req", {31'd0, imem.imem_req_out}, 32'd0);
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("redir_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("redir_req", {31'd0, imem.imem_req_out}, 32'd1);
    chk("redir_addr", imem.imem_addr_out, 32'h100);
    cyc(1, 32'h104, 0, 1, 32'h44, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 0, 0);
    chk("redir_pc", instr_pc_out, 32'h100);
    chk("redir_ins", instr_out, 32'h44);

    // flush coinciding with rvalid, buffer non-empty
    cyc(1, 32'h104, 1, 0, 0, 0, 0);
    cyc(1, 32'h108, 0, 1, 32'h66, 1, 0);
    cyc(1, 32'h300, 0, 0, 0, 0, 0);
    chk("fr_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("fr_idle_req", {31'd0, imem.imem_req_out}, 32'd1);

    // reset in the middle of a fetch
    cyc(1, 32'h400, 1, 0, 0, 0, 0);
    cyc(1, 32'h404, 0, 0, 0, 0, 0);
    cyc(0, 32'h404, 1, 0, 0, 0, 0);
    chk("mr_req", {31'd0, imem.imem_req_out}, 32'd0);
    chk("mr_adv", {31'd0, pc_advance_out}, 32'd0);
    chk("mr_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("mr_ins", instr_out, 32'd0);
    chk("mr_pc", instr_pc_out, 32'd0);
    cyc(1, 32'h500, 0, 1, 32'h77, 0, 0);
    cyc(1, 32'h500, 0, 0, 0, 0, 0);
    chk("mr_ignored", {31'd0, instr_valid_out}, 32'd0);
    cyc(1, 32'h500, 1, 0, 0, 0, 0);
    cyc(1, 32'h504, 0, 1, 32'h88, 0, 0);
    cyc(1, 32'h504, 0, 0, 0, 0, 0);
    chk("mr_after_pc", instr_pc_out, 32'h500);
    chk("mr_after_ins", instr_out, 32'h88);
    cyc(1, 32'h504, 0, 0, 0, 0, 1);
    cyc(1, 32'h504, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, the instruction buffer entry count (power of two, >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port pc_in, input, XLEN, the current fetch address from the program counter.
REQ-005 The block SHALL have port pc_advance_out, output, 1, a one-cycle pulse telling the PC to step to its next value.
REQ-006 The block SHALL have port flush_in, input, 1, the redirect (branch/exception) that discards all in-flight and buffered instructions.
REQ-007 The block SHALL have port imem_req_out, output, 1, the instruction-memory request.
REQ-008 The block SHALL have port imem_addr_out, output, XLEN, the request address.
REQ-009 The block SHALL have port imem_gnt_in, input, 1, the memory's acceptance of the request.
REQ-010 The block SHALL have port imem_rvalid_in, input, 1, marking imem_rdata_in as valid.
REQ-011 The block SHALL have port imem_rdata_in, input, XLEN, the returned instruction word.
REQ-012 The block SHALL have port instr_valid_out, output, 1, marking the buffered instruction at the head as valid.
REQ-013 The block SHALL have port instr_out, output, XLEN, the head instruction word.
REQ-014 The block SHALL have port instr_pc_out, output, XLEN, the fetch address of the head instruction.
REQ-015 The block SHALL have port instr_ready_in, input, 1, the decode stage accepting the head.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT_RSP and DRAIN, with at most one request outstanding.
REQ-017 In IDLE, imem_req_out SHALL equal (count < DEPTH) & ~flush_in, where count is the number of occupied buffer entries.
REQ-018 imem_addr_out SHALL equal pc_in combinationally.
REQ-019 On imem_req_out & imem_gnt_in, the block SHALL latch pc_in as the pending address, pulse pc_advance_out in the same cycle, and go to WAIT_RSP.
REQ-020 In WAIT_RSP and DRAIN, imem_req_out and pc_advance_out SHALL be 0.
REQ-021 In WAIT_RSP, on imem_rvalid_in & ~flush_in, the block SHALL push {pending address, imem_rdata_in} to the buffer and go to IDLE; a new request MAY issue in the next cycle.
REQ-022 A slot SHALL be reserved at grant time so that a push never meets a full buffer; a push while full SHALL be a design error (assertion).
REQ-023 instr_valid_out SHALL be (count != 0), and instr_out/instr_pc_out SHALL present the head entry with zero-cycle latency from the buffer registers.
REQ-024 On instr_valid_out & instr_ready_in, the head SHALL be popped; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 flush_in SHALL empty the buffer at the next edge, and instr_valid_out SHALL be 0 in the following cycle.
REQ-026 flush_in in WAIT_RSP without imem_rvalid_in SHALL go to DRAIN; with imem_rvalid_in in the same cycle, it SHALL discard the response and go to IDLE.
REQ-027 In DRAIN, the next imem_rvalid_in SHALL be discarded and the FSM SHALL go to IDLE; a further flush_in in DRAIN SHALL remain in DRAIN.
REQ-028 imem_gnt_in and imem_rvalid_in SHALL be ignored when no request or response is pending.
REQ-029 Buffer read/write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE, pointers=0, count=0, pending address=0; all outputs SHALL be 0 except imem_addr_out, which follows pc_in.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request, and any imem_rvalid_in arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-032 friscv_pkg SHALL hold the fetch_state_t enum, the fetch_entry_t struct {pc, instr}, and the FETCH_DEPTH default.
REQ-033 Entry storage SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/flush).

Verification
REQ-034 The bench SHALL check: after reset with gnt=1 and rvalid one cycle later, pc_in=0x0 then 0x4 yields instr_pc_out 0x0 then 0x4 with matching rdata, and one pc_advance_out pulse per grant.
REQ-035 The bench SHALL check: instr_ready_in=0 with DEPTH=2 gives exactly 2 grants, after which imem_req_out stays 0 until a pop.
REQ-036 The bench SHALL check: flush_in while in WAIT_RSP followed by late rvalid (0xDEADBEEF) leaves the word not buffered and a new request to the redirected pc_in (0x100).
REQ-037 The bench SHALL check: flush_in in the same cycle as rvalid leaves the buffer empty, FSM IDLE, and instr_valid_out=0 in the next cycle.
REQ-038 The bench SHALL check: simultaneous push and pop at count=1 leaves count 1, and the head advances in order.
REQ-039 The bench SHALL check: rst_n pulsed low in WAIT_RSP leaves all outputs 0, and a subsequent rvalid is ignored.
